// File: rtl/xm_mem_stage_pkg.sv
// Shared definitions for the XM-bundle memory stage.
// Field offsets, select encodings and the stage state enum.
package xm_mem_stage_pkg;

    localparam int ALU_LSB = 0;
    localparam int IMM_LSB = 32;
    localparam int SEL_LSB = 64;
    localparam int XM_W    = 66;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_MEM = 2'b01,
        SEL_IMM = 2'b10,
        SEL_ADD = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MEM  = 2'b01,
        WB   = 2'b10
    } state_e;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] imm;
        logic [31:0] alu;
    } xm_t;

    function automatic xm_t unpack_xm(input logic [XM_W-1:0] v);
        xm_t r;
        r.alu = v[ALU_LSB +: 32];
        r.imm = v[IMM_LSB +: 32];
        r.sel = v[SEL_LSB +: 2];
        return r;
    endfunction

endpackage

// File: rtl/xm_mem_stage_wb_select.sv
// Write-back source mux for the XM memory stage.
// Purely combinational; the ALU+imm sum wraps modulo 2^DATA_W.
module wb_select
    import xm_mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [1:0]        sel_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = alu_i;
        unique case (sel_e'(sel_i))
            SEL_ALU: data_o = alu_i;
            SEL_MEM: data_o = mem_i;
            SEL_IMM: data_o = imm_i;
            SEL_ADD: data_o = alu_i + imm_i;
            default: data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/xm_mem_stage.sv
// XM bundle consumer: load handshake, timeout and write-back.
// stall_out depends only on the registered state.
module xm_mem_stage
    import xm_mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XM_W-1:0]   xm_in,
    input  logic              xm_valid,
    output logic              stall_out,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic              wb_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] imm_in;
    logic [SEL_W-1:0]  sel_in;
    logic [DATA_W-1:0] mux_out;

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [DATA_W-1:0] alu_q;
    logic              mem_req_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_valid_q;
    logic              wb_err_q;

    assign alu_in = xm_in[ALU_LSB +: DATA_W];
    assign imm_in = xm_in[IMM_LSB +: DATA_W];
    assign sel_in = xm_in[SEL_LSB +: SEL_W];

    wb_select #(
        .DATA_W(DATA_W)
    ) u_wb_select (
        .alu_i (alu_in),
        .imm_i (imm_in),
        .mem_i (mem_rdata),
        .sel_i (sel_in),
        .data_o(mux_out)
    );

    // Single FSM; every output except stall_out is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_q      <= '0;
            mem_req_q  <= 1'b0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
            unique case (state_q)
                IDLE, WB: begin
                    if (xm_valid) begin
                        alu_q <= alu_in;
                        cnt_q <= '0;
                        if (sel_in == SEL_MEM) begin
                            state_q   <= MEM;
                            mem_req_q <= 1'b1;
                        end else begin
                            state_q    <= WB;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= mux_out;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state_q    <= WB;
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= mem_rdata;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q    <= WB;
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_err_q   <= 1'b1;
                        wb_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_out = (state_q == MEM);
    assign mem_req   = mem_req_q;
    assign mem_addr  = alu_q;
    assign wb_data   = wb_data_q;
    assign wb_valid  = wb_valid_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_xm_mem_stage.sv
// Directed bench for xm_mem_stage with a write-back scoreboard.
// Expected wb beats are queued at drive time and popped on wb_valid.
module tb_xm_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [65:0] xm_in;
    logic        xm_valid;
    logic        stall_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        wb_err;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    xm_mem_stage dut (
        .clk      (clk),
        .rst      (rst),
        .xm_in    (xm_in),
        .xm_valid (xm_valid),
        .stall_out(stall_out),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .wb_data  (wb_data),
        .wb_valid (wb_valid),
        .wb_err   (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] imm,
                         input logic [31:0] alu);
        xm_in    = {sel, imm, alu};
        xm_valid = 1'b1;
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        exp_t x;
        x.d = d;
        x.e = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_data), 32'hxxxx_xxxx);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("wb_data", wb_data, x.d);
                chk("wb_err", 32'(wb_err), 32'(x.e));
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b0;
        xm_in     = '0;
        xm_valid  = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbd", wb_data, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b1;
        tick();

        // sel=00 pass-through
        drive(2'b00, 32'h0, 32'h0000_1234);
        push(32'h0000_1234, 1'b0);
        tick();
        xm_valid = 1'b0;
        chk("t1_wbv", 32'(wb_valid), 32'd1);
        chk("t1_stall", 32'(stall_out), 32'd0);
        tick();
        chk("t1_wbv_drop", 32'(wb_valid), 32'd0);
        chk("t1_hold", wb_data, 32'h0000_1234);

        // sel=11 wrapping add
        drive(2'b11, 32'h2, 32'hFFFF_FFFF);
        push(32'h0000_0001, 1'b0);
        tick();
        xm_valid = 1'b0;
        chk("t2_wbv", 32'(wb_valid), 32'd1);
        tick();

        // load acked on the third MEM cycle
        drive(2'b01, 32'h0, 32'h0000_0100);
        tick();
        xm_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t3_stall", 32'(stall_out), 32'd1);
            chk("t3_req", 32'(mem_req), 32'd1);
            chk("t3_addr", mem_addr, 32'h0000_0100);
            tick();
        end
        chk("t3_stall3", 32'(stall_out), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        push(32'hDEAD_BEEF, 1'b0);
        tick();
        mem_ack = 1'b0;
        chk("t3_wbv", 32'(wb_valid), 32'd1);
        chk("t3_req_off", 32'(mem_req), 32'd0);
        chk("t3_stall_off", 32'(stall_out), 32'd0);
        tick();
        chk("t3_wbv_drop", 32'(wb_valid), 32'd0);

        // load never acked -> timeout
        drive(2'b01, 32'h0, 32'h0000_0200);
        push(32'h0, 1'b1);
        tick();
        xm_valid = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("t4_req_cycles", 32'(n), 32'd15);
        chk("t4_wbv", 32'(wb_valid), 32'd1);
        chk("t4_err", 32'(wb_err), 32'd1);
        tick();

        // ack on the expiry cycle wins
        drive(2'b01, 32'h0, 32'h0000_0280);
        tick();
        xm_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("t4b_req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        push(32'h1357_9BDF, 1'b0);
        tick();
        mem_ack = 1'b0;
        chk("t4b_err", 32'(wb_err), 32'd0);
        tick();

        // ack in the first MEM cycle
        drive(2'b01, 32'h0, 32'h0000_02C0);
        tick();
        xm_valid  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        push(32'hAAAA_5555, 1'b0);
        tick();
        mem_ack = 1'b0;
        chk("t4c_wbv", 32'(wb_valid), 32'd1);
        tick();

        // back-to-back accepts
        drive(2'b10, 32'h5, 32'h0);
        push(32'h5, 1'b0);
        tick();
        chk("t5_wbv1", 32'(wb_valid), 32'd1);
        drive(2'b00, 32'h0, 32'h7);
        push(32'h7, 1'b0);
        tick();
        xm_valid = 1'b0;
        chk("t5_wbv2", 32'(wb_valid), 32'd1);
        chk("t5_wbd2", wb_data, 32'h7);
        tick();

        // xm_valid during MEM is not captured
        drive(2'b01, 32'h0, 32'h0000_0300);
        tick();
        drive(2'b00, 32'h0, 32'h0000_0999);
        tick();
        xm_valid = 1'b0;
        chk("t5_addr", mem_addr, 32'h0000_0300);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        push(32'hCAFE_0001, 1'b0);
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        chk("t5_no_extra", 32'(wb_valid), 32'd0);

        // reset mid-load
        drive(2'b01, 32'h0, 32'h0000_0400);
        tick();
        xm_valid = 1'b0;
        tick();
        chk("t6_req_pre", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_stall", 32'(stall_out), 32'd0);
        tick();
        tick();
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_1234;
        tick();
        mem_ack = 1'b0;
        chk("t6_no_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("t6_no_wb2", 32'(wb_valid), 32'd0);
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
